// File: rtl/mult_arbiter.sv
// mult_arbiter: a round-robin arbiter that lets NREQ requesters share one
// 3-stage pipelined signed fractional multiplier (Q1.(BITSIZE-1)).
//
// Ports:
//   i_clk        system clock (OSC domain)
//   i_rst        synchronous active-high reset
//   i_frame      one-cycle sample-frame strobe
//   i_req        per-requester level request
//   i_in1/i_in2  packed operands, requester k at [k*BITSIZE +: BITSIZE]
//   o_ack        one-hot pulse, operands of requester k captured
//   o_out        signed product result (held when o_out_valid=0)
//   o_out_valid  one-cycle pulse, o_out/o_out_id valid
//   o_out_id     requester index of o_out
//   o_missed     sticky per-requester overrun flags
//   i_clr_missed clears o_missed (a same-cycle frame set wins)
module mult_arbiter #(
    parameter int BITSIZE = 16,
    parameter int NREQ    = 4,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_frame,
    input  logic [NREQ-1:0]         i_req,
    input  logic [NREQ*BITSIZE-1:0] i_in1,
    input  logic [NREQ*BITSIZE-1:0] i_in2,
    output logic [NREQ-1:0]         o_ack,
    output logic [BITSIZE-1:0]      o_out,
    output logic                    o_out_valid,
    output logic [IDW-1:0]          o_out_id,
    output logic [NREQ-1:0]         o_missed,
    input  logic                    i_clr_missed
);

    localparam int PW = 2 * BITSIZE;

    // arbitration state
    logic [IDW-1:0]            r_ptr;
    logic [NREQ-1:0]           r_ack;
    logic [NREQ-1:0]           r_missed;

    // stage 1: captured operands
    logic signed [BITSIZE-1:0] r_s1_a;
    logic signed [BITSIZE-1:0] r_s1_b;
    logic [IDW-1:0]            r_s1_id;
    logic                      r_s1_v;

    // stage 2: full-precision product
    logic signed [PW-1:0]      r_s2_p;
    logic [IDW-1:0]            r_s2_id;
    logic                      r_s2_v;

    // stage 3: output registers
    logic [BITSIZE-1:0]        r_out;
    logic [IDW-1:0]            r_out_id;
    logic                      r_out_v;

    // combinational grant
    logic                      w_gnt_any;
    logic [IDW-1:0]            w_gnt_id;
    logic [NREQ-1:0]           w_gnt_oh;
    logic [BITSIZE-1:0]        w_gnt_a;
    logic [BITSIZE-1:0]        w_gnt_b;

    // output formatting
    logic                      w_sat;
    logic [BITSIZE-1:0]        w_trunc;
    logic [BITSIZE-1:0]        w_res;
    logic                      w_unused;

    logic [NREQ-1:0]           w_missed_nxt;

    // Search from r_ptr upward, wrapping; IDW-bit addition wraps
    // naturally because NREQ is a power of two.
    always_comb begin : arb
        logic [IDW-1:0] idx;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        idx       = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = r_ptr + IDW'(i);
            if (!w_gnt_any && i_req[idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = idx;
            end
        end
    end

    always_comb begin
        w_gnt_oh = '0;
        if (w_gnt_any) begin
            w_gnt_oh[w_gnt_id] = 1'b1;
        end
    end

    assign w_gnt_a = i_in1[w_gnt_id*BITSIZE +: BITSIZE];
    assign w_gnt_b = i_in2[w_gnt_id*BITSIZE +: BITSIZE];

    // Only (-1.0)*(-1.0) reaches +2^(PW-2); everything else fits
    // the truncated slice.
    assign w_sat   = (r_s2_p[PW-1:PW-2] == 2'b01);
    assign w_trunc = r_s2_p[PW-2:BITSIZE-1];
    assign w_res   = w_sat ? {1'b0, {(BITSIZE-1){1'b1}}} : w_trunc;

    // low product bits are discarded by the truncation
    assign w_unused = ^r_s2_p[BITSIZE-2:0];

    // clear first, then the frame sets, so a same-cycle set wins
    always_comb begin
        w_missed_nxt = i_clr_missed ? '0 : r_missed;
        if (i_frame) begin
            w_missed_nxt = w_missed_nxt | (i_req & ~w_gnt_oh);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr    <= '0;
            r_ack    <= '0;
            r_missed <= '0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_id  <= '0;
            r_s1_v   <= 1'b0;
            r_s2_p   <= '0;
            r_s2_id  <= '0;
            r_s2_v   <= 1'b0;
            r_out    <= '0;
            r_out_id <= '0;
            r_out_v  <= 1'b0;
        end else begin
            r_ack    <= w_gnt_oh;
            r_missed <= w_missed_nxt;
            r_s1_v   <= w_gnt_any;
            if (w_gnt_any) begin
                r_ptr   <= w_gnt_id + IDW'(1);
                r_s1_a  <= w_gnt_a;
                r_s1_b  <= w_gnt_b;
                r_s1_id <= w_gnt_id;
            end
            r_s2_v  <= r_s1_v;
            if (r_s1_v) begin
                r_s2_p  <= r_s1_a * r_s1_b;
                r_s2_id <= r_s1_id;
            end
            r_out_v <= r_s2_v;
            if (r_s2_v) begin
                r_out    <= w_res;
                r_out_id <= r_s2_id;
            end
        end
    end

    assign o_ack       = r_ack;
    assign o_out       = r_out;
    assign o_out_valid = r_out_v;
    assign o_out_id    = r_out_id;
    assign o_missed    = r_missed;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed-vector bench for mult_arbiter.
// Inputs change 1ns after posedge; outputs sampled at the same point.
module tb_mult_arbiter;

    localparam int W  = 16;
    localparam int NR = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            frame;
    logic [NR-1:0]   req;
    logic [NR*W-1:0] in1;
    logic [NR*W-1:0] in2;
    logic [NR-1:0]   ack;
    logic [W-1:0]    out;
    logic            out_valid;
    logic [IW-1:0]   out_id;
    logic [NR-1:0]   missed;
    logic            clr_missed;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mult_arbiter #(.BITSIZE(W), .NREQ(NR)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_frame     (frame),
        .i_req       (req),
        .i_in1       (in1),
        .i_in2       (in2),
        .o_ack       (ack),
        .o_out       (out),
        .o_out_valid (out_valid),
        .o_out_id    (out_id),
        .o_missed    (missed),
        .i_clr_missed(clr_missed)
    );

    task automatic check(input string tag,
                         input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int k, input int a, input int b);
        in1[k*W +: W] = W'(a);
        in2[k*W +: W] = W'(b);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req        = '0;
        frame      = 1'b0;
        clr_missed = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // single isolated multiply by requester k
    task automatic do_one(input string tag, input int k,
                          input int a, input int b, input int exp);
        set_ops(k, a, b);
        req    = '0;
        req[k] = 1'b1;
        tick();
        check({tag, "_ack"}, ack, 32'(1 << k));
        req = '0;
        tick();
        check({tag, "_v1"}, out_valid, 0);
        tick();
        check({tag, "_v2"}, out_valid, 1);
        check({tag, "_out"}, $signed(out), exp);
        check({tag, "_id"}, out_id, k);
    endtask

    initial begin
        in1 = '0;
        in2 = '0;
        do_reset();
        check("rst_ack", ack, 0);
        check("rst_vld", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_id", out_id, 0);
        check("rst_missed", missed, 0);

        // single request, then hold on idle
        do_one("single", 0, 16384, 16384, 8192);
        tick();
        check("single_idle_vld", out_valid, 0);
        check("single_hold", $signed(out), 8192);

        // full contention from reset: out = 1000*(k+1)/2
        do_reset();
        for (int k = 0; k < NR; k++) set_ops(k, 1000 * (k + 1), 16384);
        req = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            check($sformatf("full_ack%0d", c), ack, 32'(1 << (c % 4)));
            if (c >= 2) begin
                check($sformatf("full_vld%0d", c), out_valid, 1);
                check($sformatf("full_id%0d", c), out_id, (c - 2) % 4);
                check($sformatf("full_out%0d", c), $signed(out),
                      500 * ((c - 2) % 4 + 1));
            end else begin
                check($sformatf("full_vld%0d", c), out_valid, 0);
            end
        end
        req = '0;

        // round robin between 0 and 2
        do_reset();
        set_ops(0, 8192, 8192);
        set_ops(2, -16384, 16384);
        req = 4'b0101;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("rr_ack%0d", c), ack,
                  (c % 2 == 0) ? 32'h1 : 32'h4);
            if (c >= 2) begin
                check($sformatf("rr_id%0d", c), out_id,
                      (c % 2 == 0) ? 0 : 2);
                check($sformatf("rr_out%0d", c), $signed(out),
                      (c % 2 == 0) ? 2048 : -8192);
            end
        end
        req = '0;
        tick();
        tick();
        tick();

        // saturation, sign and truncation corners
        do_one("sat", 1, -32768, -32768, 32767);
        do_one("neg1", 1, -1, 1, -1);
        do_one("max", 1, 32767, 32767, 32766);
        do_one("minmax", 3, -32768, 32767, -32767);
        do_one("half", 3, 16384, -1, -1);

        // missed flags
        do_reset();
        req   = 4'b0011;
        frame = 1'b1;
        tick();
        check("miss_ack0", ack, 32'h1);
        check("miss_set", missed, 32'h2);
        req   = 4'b0010;
        frame = 1'b0;
        tick();
        check("miss_ack1", ack, 32'h2);
        check("miss_sticky", missed, 32'h2);
        req        = 4'b1100;
        frame      = 1'b1;
        clr_missed = 1'b1;
        tick();
        check("miss_clrset_ack", ack, 32'h4);
        check("miss_clrset", missed, 32'h8);
        req        = 4'b1000;
        frame      = 1'b0;
        clr_missed = 1'b0;
        tick();
        check("miss_ack3", ack, 32'h8);
        check("miss_hold", missed, 32'h8);
        req        = '0;
        clr_missed = 1'b1;
        tick();
        check("miss_clr", missed, 0);
        clr_missed = 1'b0;
        frame      = 1'b1;
        tick();
        check("miss_idle_frame", missed, 0);
        frame = 1'b0;
        tick();
        tick();

        // reset mid-pipeline; out holds a nonzero value beforehand
        set_ops(2, 16384, 16384);
        req = 4'b0100;
        tick();
        check("mid_ack2", ack, 32'h4);
        req = '0;
        rst = 1'b1;
        tick();
        check("mid_ack_off", ack, 0);
        check("mid_vld0", out_valid, 0);
        rst = 1'b0;
        tick();
        check("mid_vld1", out_valid, 0);
        check("mid_out", out, 0);
        tick();
        check("mid_vld2", out_valid, 0);
        req = 4'b1111;
        tick();
        check("mid_ptr0", ack, 32'h1);
        req = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Time-shares one pipelined signed BITSIZE×BITSIZE fractional multiplier among NREQ requesters (envelope VCAs, modulator gains, mixer trims) in the OSC clock domain. Requesters use a req/ack handshake; one operand pair is accepted per clock under round-robin priority, and each result comes back tagged with the requester index. Per-requester sticky flags record requests still unserved when a sample-frame strobe arrives, so firmware can detect that a sample period was overrun.

## Interface
- BITSIZE, 16, sample width, signed Q1.(BITSIZE-1)
- NREQ, 4, number of requesters (power of two, ≥2)
- IDW, $clog2(NREQ), width of requester index
- clk  in  1  system clock (OSC, 49.152 MHz)
- rst  in  1  synchronous, active-high reset
- frame  in  1  one-cycle strobe once per audio sample (DACLRC edge, already synchronised to clk)
- req  in  NREQ  request per requester, level
- in1  in  NREQ*BITSIZE  operand A, requester k at [k*BITSIZE +: BITSIZE]
- in2  in  NREQ*BITSIZE  operand B, same packing
- ack  out  NREQ  one-hot pulse: operands of requester k captured this cycle
- out  out  BITSIZE  signed product result
- out_valid  out  1  one-cycle pulse, out/out_id valid
- out_id  out  IDW  requester index for out
- missed  out  NREQ  sticky: request pending and un-acked at a frame strobe
- clr_missed  in  1  clears all missed bits

## Operation
- Reset values: ack=0, out=0, out_valid=0, out_id=0, missed=0, priority pointer ptr=0, pipeline valid bits=0.
- Arbitration (combinational on req and ptr, registered into ack): grant the first k with req[k]=1, searching ptr, ptr+1, …, wrapping mod NREQ. At most one grant per cycle.
- On grant to k: ack[k]=1 for one cycle, stage-1 registers capture in1[k], in2[k], id=k, valid=1; ptr ← (k+1) mod NREQ. No grant: ack=0, stage-1 valid=0, ptr unchanged.
- Handshake: requester holds req and operands stable until it sees ack. req still high in the cycle after ack is a new request and is re-arbitrated normally (back-to-back from one requester allowed when no one else requests).
- Stage 2: signed 2·BITSIZE-bit product P = A·B registered with id and valid.
- Stage 3 (output regs): out = P[2·BITSIZE-2 : BITSIZE-1] (arithmetic >>> (BITSIZE-1), truncation toward −∞); exception A=B=−2^(BITSIZE-1) → out = 2^(BITSIZE-1)−1 (saturate). out_valid/out_id from stage-2 valid/id. When out_valid=0, out and out_id hold their previous values.
- Missed: on a frame cycle, for each k with req[k]=1 and no grant to k in that cycle, missed[k] ← 1. A grant to k in the frame cycle does not set missed[k].
- clr_missed and frame in the same cycle: clear is applied first, then new bits set (set wins).
- Fairness bound: a continuously held request is acked within NREQ cycles.

## Timing
- Latency: ack in cycle N → out_valid in cycle N+2 (operands sampled at the edge ending the cycle before ack is visible; ack is registered).
- Precisely: req[k] high at edge E0 with arbitration win → ack[k] high after E0; stage-2 at E1; out_valid high after E2.
- Throughput: one result per clock sustained; no bubbles when any req is high.
- Reset mid-operation: all in-flight operations discarded; no out_valid is produced for operations acked before rst; ack deasserts the cycle after rst sampled high.
- frame has no effect on arbitration or pipeline, only on missed.

## Test plan
- Single request: reset, req[0]=1, in1[0]=16384, in2[0]=16384 → ack[0] one pulse, out_valid two cycles later with out=8192, out_id=0.
- Full contention from reset: req=4'b1111 held → ack order 0,1,2,3,0,… in consecutive cycles; out_id sequence identical, delayed 2 cycles; one out_valid per cycle.
- Round robin two requesters: req[0], req[2] held, ptr=0 → grants 0,2,0,2; with in1=−16384, in2=16384 for requester 2 → out=−8192.
- Saturation and sign: in1=in2=−32768 → out=32767; in1=−1, in2=1 → out=−1 (truncation toward −∞); in1=32767, in2=32767 → out=32766.
- Missed flag: ptr=0, req[0] and req[1] rise together with frame → ack[0], missed=4'b0010; next cycle ack[1]; clr_missed → missed=0; clr_missed with frame and req[3] pending unserved → missed=4'b1000.
- Reset mid-pipeline: ack[2] then rst asserted next cycle → no out_valid afterwards, out=0, ptr=0 (next req=4'b1111 grants 0 first).
